raster_pixel_source: RTL and testbench

Frame-level raster source feeding the row-window stages, such as the R2 row-sum stage, with one pixel per cycle. On a start pulse it reads a ROWS×COLS frame from a synchronous single-port buffer (1-cycle read latency) in raster order. It presents each pixel with a valid strobe, row/column position and a last-row flag, honouring downstream backpressure through a 2-entry output queue. It pulses a frame-complete flag once the last pixel has been accepted.

---
 rtl/raster_pixel_source_pkg.sv | 28 ++
 rtl/raster_pixel_source_pix_fifo2.sv | 73 +++++++
 rtl/raster_pixel_source.sv | 203 ++++++++++++++++++++
 tb/tb_raster_pixel_source.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pixel_source_pkg.sv
// -----------------------------------------------------------------------------
// raster_pixel_source_pkg
//   Shared definitions for the raster pixel source:
//     - state_e     : frame sequencer state encoding
//     - FIFO_DEPTH  : depth of the output queue (also the read-credit limit)
//     - cnt_w()     : counter width for a count of n positions (min 1 bit)
//     - addr_w()    : frame-buffer address width for a rows x cols frame
// -----------------------------------------------------------------------------
package raster_pixel_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int FIFO_DEPTH = 2;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int addr_w(input int rows, input int cols);
        return cnt_w(rows * cols);
    endfunction

endpackage

// File: rtl/raster_pixel_source_pix_fifo2.sv
// -----------------------------------------------------------------------------
// raster_pixel_source_pix_fifo2
//   Two-entry show-ahead FIFO. The oldest entry is always visible on rd_data_o
//   while count_o != 0; rd_en_i pops it. A push and a pop in the same cycle are
//   accepted at any occupancy, including full.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i         push wr_data_i
//   wr_data_i       data to push
//   rd_en_i         pop the head entry (ignored when empty)
//   rd_data_o       head entry
//   count_o         current occupancy, 0..2
// -----------------------------------------------------------------------------
module raster_pixel_source_pix_fifo2
    import raster_pixel_source_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_wr, do_rd;

    always_comb begin
        do_rd    = rd_en_i && (count_q != 2'd0);
        // When full, a push is only taken if the head is leaving this cycle;
        // the write then lands in the slot being vacated.
        do_wr    = wr_en_i && ((count_q != 2'(FIFO_DEPTH)) || do_rd);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_rd) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_wr) - 2'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/raster_pixel_source.sv
// -----------------------------------------------------------------------------
// raster_pixel_source
//   On start_i, reads a ROWS x COLS frame from a synchronous frame buffer
//   (1-cycle read latency) in raster order and presents it one pixel per cycle
//   with valid/ready handshaking, row/column position and a last-row flag.
//   Reads are credit-limited so that queued plus in-flight pixels never exceed
//   the 2-entry output queue. frame_done_o pulses once after the last pixel is
//   accepted.
//
// Optional feature (macro RASTER_SRC_LINE_GAP_EN):
//   When defined, valid_o is held low for one cycle after the transfer of the
//   last pixel of every row except the final row, giving consumers a
//   row-boundary bubble. Fetching continues during the bubble.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_i         frame start, honoured only when idle
//   mem_rd_o        frame-buffer read strobe
//   mem_addr_o      frame-buffer read address (row*COLS + col)
//   mem_data_i      read data, valid the cycle after mem_rd_o
//   ready_i         downstream accepts the presented pixel
//   valid_o         pixel_o / row_o / col_o are valid
//   pixel_o         pixel value
//   col_o, row_o    position of the presented pixel
//   row_eq_max_o    row_o is the last row
//   frame_done_o    one-cycle pulse after the final transfer
//   busy_o          a frame is in progress
// -----------------------------------------------------------------------------
module raster_pixel_source
    import raster_pixel_source_pkg::*;
#(
    parameter  int COLS   = 7,
    parameter  int ROWS   = 7,
    parameter  int DATA_W = 8,
    localparam int AW     = addr_w(ROWS, COLS),
    localparam int CW     = cnt_w(COLS),
    localparam int RW     = cnt_w(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              mem_rd_o,
    output logic [AW-1:0]     mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] pixel_o,
    output logic [CW-1:0]     col_o,
    output logic [RW-1:0]     row_o,
    output logic              row_eq_max_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS * COLS - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);

    state_e          state_q;
    logic            frame_done_q;
    logic            busy_q;

    logic [AW-1:0]   addr_q, addr_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;

    logic [1:0]      fifo_count;
    logic            fifo_nonempty;
    logic            pop;
    logic [2:0]      pending;
    logic            rd_req;
    logic            last_rd;

    // Output queue; read data is pushed the cycle it arrives.
    raster_pixel_source_pix_fifo2 #(
        .DATA_W (DATA_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (inflight_q),
        .wr_data_i (mem_data_i),
        .rd_en_i   (pop),
        .rd_data_o (pixel_o),
        .count_o   (fifo_count)
    );

    assign fifo_nonempty = (fifo_count != 2'd0);

`ifdef RASTER_SRC_LINE_GAP_EN
    logic gap_q, gap_d;

    always_comb begin
        gap_d = pop && (col_q == LAST_COL) && (row_q != LAST_ROW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
        end
    end

    assign valid_o = fifo_nonempty && !gap_q;
`else
    assign valid_o = fifo_nonempty;
`endif

    assign pop = valid_o && ready_i;

    // Pixels still owed to the queue once this cycle's pop leaves: crediting
    // the pop keeps one read per cycle going while the consumer keeps up.
    assign pending = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign rd_req  = (state_q == ST_FETCH) && (pending < 3'(FIFO_DEPTH));
    assign last_rd = rd_req && (addr_q == LAST_ADDR);

    always_comb begin
        addr_d     = addr_q;
        inflight_d = rd_req;
        if ((state_q == ST_IDLE) && start_i) begin
            addr_d = '0;
        end else if (rd_req && !last_rd) begin
            // Holds at LAST_ADDR so no address past the frame is ever formed.
            addr_d = addr_q + AW'(1);
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pop) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            inflight_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    // In DRAIN every read has been issued, so pending reaching zero means the
    // final pixel is being accepted this cycle (or already was).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (last_rd) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pending == 3'd0) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_o     = rd_req;
    assign mem_addr_o   = addr_q;
    assign col_o        = col_q;
    assign row_o        = row_q;
    assign row_eq_max_o = (row_q == LAST_ROW);
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_raster_pixel_source.sv
// -----------------------------------------------------------------------------
// tb_raster_pixel_source
//   Drives whole frames through raster_pixel_source with a behavioural frame
//   buffer and checks the accepted pixel stream, positions, timing and the
//   read-credit rule against a raster-order reference model.
// -----------------------------------------------------------------------------
module tb_raster_pixel_source;

    localparam int COLS = 7;
    localparam int ROWS = 7;
    localparam int N    = COLS * ROWS;
    localparam int MAXC = 400;
`ifdef RASTER_SRC_LINE_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif
    localparam int EXP_DONE = N + 3 + GAP * (ROWS - 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       mem_rd_o;
    logic [5:0] mem_addr_o;
    logic [7:0] mem_data_i = '0;
    logic       ready_i = 1'b0;
    logic       valid_o;
    logic [7:0] pixel_o;
    logic [2:0] col_o;
    logic [2:0] row_o;
    logic       row_eq_max_o;
    logic       frame_done_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    raster_pixel_source #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .DATA_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .pixel_o      (pixel_o),
        .col_o        (col_o),
        .row_o        (row_o),
        .row_eq_max_o (row_eq_max_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Frame buffer model: 1-cycle read latency.
    logic [7:0] mem_arr [64];
    always @(posedge clk) begin
        if (mem_rd_o && (int'(mem_addr_o) < N)) mem_data_i <= mem_arr[mem_addr_o];
    end

    // Capture of one frame run.
    bit cv [MAXC];
    bit cr [MAXC];
    bit crd [MAXC];
    bit cbusy [MAXC];
    int cpix [MAXC];
    int x_pix[$], x_row[$], x_col[$], x_rem[$], x_cyc[$];
    int ncyc, done_cnt, done_cyc, nreads, bad_addr, end_row, end_col;

    function automatic int gaps_before(input int i);
        return GAP * (i / COLS);
    endfunction

    task automatic fill_mem(input bit by_addr);
        for (int i = 0; i < 64; i++) mem_arr[i] = by_addr ? 8'(i) : 8'($urandom_range(0, 255));
    endtask

    // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic capture(input int mode, input int extra_start);
        x_pix.delete(); x_row.delete(); x_col.delete(); x_rem.delete(); x_cyc.delete();
        ncyc = 0; done_cnt = 0; done_cyc = -1; nreads = 0; bad_addr = 0;
        for (int k = 0; k < MAXC; k++) begin
            @(posedge clk); #1;
            start_i = (k == 0) || (k == extra_start);
            case (mode)
                0: ready_i = 1'b1;
                1: ready_i = ((k % 4) == 0) || ((k % 4) == 3);
                default: ready_i = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            cv[k] = valid_o; cr[k] = ready_i; crd[k] = mem_rd_o;
            cbusy[k] = busy_o; cpix[k] = int'(pixel_o);
            if (valid_o && ready_i) begin
                x_pix.push_back(int'(pixel_o)); x_row.push_back(int'(row_o));
                x_col.push_back(int'(col_o)); x_rem.push_back(int'(row_eq_max_o));
                x_cyc.push_back(k);
            end
            if (mem_rd_o) begin
                nreads++;
                if (int'(mem_addr_o) >= N) bad_addr++;
            end
            if (frame_done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            end_row = int'(row_o); end_col = int'(col_o);
            ncyc = k + 1;
            if (done_cyc >= 0 && k >= done_cyc + 4) break;
        end
        start_i = 1'b0;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_o, mem_rd_o, mem_addr_o, pixel_o, col_o, row_o, row_eq_max_o,
             frame_done_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b rd=%b a=%0d p=%0d c=%0d r=%0d m=%b d=%b b=%b required all 0",
                     valid_o, mem_rd_o, mem_addr_o, pixel_o, col_o, row_o, row_eq_max_o, frame_done_o, busy_o);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_o, mem_rd_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got v=%b rd=%b busy=%b required 000", valid_o, mem_rd_o, busy_o);
        end
    endtask

    task automatic test_stream();
        fill_mem(1'b1);
        capture(0, -1);
        checks++;
        if (x_pix.size() != N) begin
            errors++; $display("FAIL stream_count: got %0d required %0d", x_pix.size(), N);
        end
        for (int i = 0; i < N && i < x_pix.size(); i++) begin
            checks++;
            if (x_pix[i] != i) begin
                errors++; $display("FAIL stream_pixel[%0d]: got %0d required %0d", i, x_pix[i], i);
            end
            checks++;
            if (x_cyc[i] != 3 + i + gaps_before(i)) begin
                errors++; $display("FAIL stream_cycle[%0d]: got %0d required %0d", i, x_cyc[i], 3 + i + gaps_before(i));
            end
            checks++;
            if (x_row[i] != i / COLS || x_col[i] != i % COLS || x_rem[i] != int'((i / COLS) == ROWS - 1)) begin
                errors++;
                $display("FAIL stream_pos[%0d]: got row=%0d col=%0d max=%0d required row=%0d col=%0d max=%0d",
                         i, x_row[i], x_col[i], x_rem[i], i / COLS, i % COLS, int'((i / COLS) == ROWS - 1));
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != EXP_DONE) begin
            errors++; $display("FAIL stream_done: got count=%0d cycle=%0d required count=1 cycle=%0d", done_cnt, done_cyc, EXP_DONE);
        end
        for (int k = 0; k < ncyc; k++) begin
            checks++;
            if (cbusy[k] != (k >= 1 && k <= EXP_DONE)) begin
                errors++; $display("FAIL stream_busy[%0d]: got %0d required %0d", k, cbusy[k], (k >= 1 && k <= EXP_DONE));
            end
        end
        checks++;
        if (nreads != N || bad_addr != 0) begin
            errors++; $display("FAIL stream_reads: got reads=%0d bad_addr=%0d required reads=%0d bad_addr=0", nreads, bad_addr, N);
        end
        checks++;
        if (end_row != 0 || end_col != 0) begin
            errors++; $display("FAIL stream_wrap: got row=%0d col=%0d required 0 0", end_row, end_col);
        end
    endtask

    task automatic test_backpressure(input int mode);
        int r_cnt, t_cnt, xf;
        fill_mem(1'b0);
        capture(mode, -1);
        checks++;
        if (x_pix.size() != N) begin
            errors++; $display("FAIL bp%0d_count: got %0d required %0d", mode, x_pix.size(), N);
        end
        for (int i = 0; i < N && i < x_pix.size(); i++) begin
            checks++;
            if (x_pix[i] != int'(mem_arr[i]) || x_row[i] != i / COLS || x_col[i] != i % COLS) begin
                errors++;
                $display("FAIL bp%0d_pixel[%0d]: got pix=%0d row=%0d col=%0d required pix=%0d row=%0d col=%0d",
                         mode, i, x_pix[i], x_row[i], x_col[i], mem_arr[i], i / COLS, i % COLS);
            end
        end
        r_cnt = 0; t_cnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            xf = int'(cv[k] && cr[k]);
            if (crd[k]) begin
                checks++;
                if (r_cnt - t_cnt - xf >= 2) begin
                    errors++; $display("FAIL bp%0d_credit[%0d]: got outstanding=%0d with read required <2", mode, k, r_cnt - t_cnt - xf);
                end
            end
            if (cv[k] && !cr[k] && k + 1 < ncyc) begin
                checks++;
                if (!cv[k + 1] || cpix[k + 1] != cpix[k]) begin
                    errors++; $display("FAIL bp%0d_hold[%0d]: got valid=%0d pix=%0d required valid=1 pix=%0d", mode, k, cv[k + 1], cpix[k + 1], cpix[k]);
                end
            end
            r_cnt += int'(crd[k]);
            t_cnt += xf;
        end
        checks++;
        if (done_cnt != 1 || x_cyc.size() == 0 || done_cyc != x_cyc[x_cyc.size() - 1] + 1) begin
            errors++; $display("FAIL bp%0d_done: got count=%0d cycle=%0d required count=1 one cycle after last transfer", mode, done_cnt, done_cyc);
        end
    endtask

    task automatic test_start_ignored();
        fill_mem(1'b0);
        capture(0, 10);
        checks++;
        if (x_pix.size() != N || nreads != N) begin
            errors++; $display("FAIL start_ignored_count: got xfers=%0d reads=%0d required %0d", x_pix.size(), nreads, N);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != EXP_DONE) begin
            errors++; $display("FAIL start_ignored_done: got count=%0d cycle=%0d required count=1 cycle=%0d", done_cnt, done_cyc, EXP_DONE);
        end
        checks++;
        if (cbusy[ncyc - 1] != 1'b0) begin
            errors++; $display("FAIL start_ignored_idle: got busy=1 required 0");
        end
    endtask

    task automatic test_midframe_reset();
        int target;
        target = 3 + 20 + gaps_before(20);
        fill_mem(1'b1);
        @(posedge clk); #1 start_i = 1'b1; ready_i = 1'b1;
        for (int k = 1; k <= target; k++) begin
            @(posedge clk); #1 start_i = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (!valid_o || pixel_o != 8'd20) begin
            errors++; $display("FAIL midreset_pixel20: got valid=%b pix=%0d required valid=1 pix=20", valid_o, pixel_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({valid_o, mem_rd_o, mem_addr_o, pixel_o, col_o, row_o, row_eq_max_o,
             frame_done_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b rd=%b a=%0d p=%0d c=%0d r=%0d b=%b required all 0",
                     valid_o, mem_rd_o, mem_addr_o, pixel_o, col_o, row_o, busy_o);
        end
        rst = 1'b0;
        ready_i = 1'b0;
        capture(0, -1);
        checks++;
        if (x_pix.size() == 0 || x_pix[0] != 0 || x_cyc[0] != 3) begin
            errors++; $display("FAIL midreset_restart: got xfers=%0d first_pix=%0d first_cyc=%0d required pix=0 cyc=3",
                               x_pix.size(), (x_pix.size() > 0) ? x_pix[0] : -1, (x_cyc.size() > 0) ? x_cyc[0] : -1);
        end
        checks++;
        if (x_pix.size() != N || done_cyc != EXP_DONE) begin
            errors++; $display("FAIL midreset_frame: got xfers=%0d done=%0d required %0d %0d", x_pix.size(), done_cyc, N, EXP_DONE);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure(1);
        test_backpressure(2);
        test_start_ignored();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
